// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM encoding and byte-lane helpers.
package mem_pkg;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWrite,
    StDone
  } state_e;

  // Illegal op or a half/word access not aligned to its size.
  function automatic logic op_fault(input logic [3:0] op, input logic [1:0] lo);
    logic f;
    f = 1'b0;
    if (op > OP_SW) f = 1'b1;
    if ((op == OP_LH || op == OP_LHU || op == OP_SH) && lo[0]) f = 1'b1;
    if ((op == OP_LW || op == OP_SW) && (lo != 2'b00)) f = 1'b1;
    return f;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lo,
                                               input logic [3:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'b0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the word just read with the store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] lo,
                                             input logic [3:0] op, input logic [31:0] wdata);
    logic [31:0] m;
    m = word;
    case (op)
      OP_SB: m[{lo, 3'b000} +: 8] = wdata[7:0];
      OP_SH: begin
        if (lo[1]) m[31:16] = wdata[15:0];
        else       m[15:0]  = wdata[15:0];
      end
      OP_SW:   m = wdata;
      default: m = word;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: load extract/extend and store read-modify-write merge.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  op,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  always_comb begin
    load_data   = load_extract(word, addr_lo, op);
    merged_word = lane_merge(word, addr_lo, op, wdata);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a word-only data memory.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_pc,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [31:0]       mem_pc,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enabled,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   merged_q, merged_d;
  logic                fault_q, fault_d;

  logic                accept;
  logic                req_fault;
  logic                busy;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   merged_word;

  mem_lane_align u_lane_align (
    .word        (mem_read_data),
    .addr_lo     (addr_q[1:0]),
    .op          (op_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  assign accept    = req_valid & req_ready;
  assign req_fault = op_fault(req_op, req_addr[1:0]);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    merged_d = merged_q;
    fault_d  = fault_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          pc_d    = req_pc;
          addr_d  = req_addr;
          op_d    = req_op;
          wdata_d = req_wdata;
          rdata_d = '0;
          fault_d = req_fault;
          state_d = req_fault ? StDone : StAccess;
        end
      end
      StAccess: begin
        if (op_q == OP_SB || op_q == OP_SH) begin
          merged_d = merged_word;
          state_d  = StWrite;
        end else begin
          if (op_q <= OP_LW) rdata_d = load_data;
          state_d = StDone;
        end
      end
      StWrite: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy              = (state_q == StAccess) || (state_q == StWrite);
    req_ready         = (state_q == StIdle) || (state_q == StDone);
    resp_valid        = (state_q == StDone);
    resp_rdata        = resp_valid ? rdata_q : '0;
    resp_fault        = resp_valid & fault_q;
    mem_address       = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_pc            = busy ? pc_q : '0;
    // Gated by reset so an abandoned access never commits a write.
    mem_write_enabled = !reset && (((state_q == StAccess) && (op_q == OP_SW)) ||
                                   (state_q == StWrite));
    mem_write_data    = '0;
    if (state_q == StAccess && op_q == OP_SW) mem_write_data = wdata_q;
    else if (state_q == StWrite)              mem_write_data = merged_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      addr_q   <= '0;
      op_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      merged_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      op_q     <= op_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      merged_q <= merged_d;
      fault_q  <= fault_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-addressed memory model.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic [31:0] req_addr;
  logic [3:0]  req_op;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_pc;
  logic [31:0] mem_address;
  logic        mem_write_enabled;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:255];
  logic [7:0]  ref_mem [0:1023];
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_data;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_pc            (req_pc),
    .req_addr          (req_addr),
    .req_op            (req_op),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_fault        (resp_fault),
    .mem_pc            (mem_pc),
    .mem_address       (mem_address),
    .mem_write_enabled (mem_write_enabled),
    .mem_write_data    (mem_write_data),
    .mem_read_data     (mem_read_data)
  );

  always #5 clock = ~clock;

  assign mem_read_data = mem[mem_address[9:2]];

  always @(posedge clock) begin
    if (poke_en) mem[poke_idx] <= poke_data;
    else if (mem_write_enabled) mem[mem_address[9:2]] <= mem_write_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a - (a % 4);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic bit ref_fault(input int op, input logic [31:0] addr);
    if (op > 7) return 1'b1;
    if ((op == 2 || op == 3 || op == 6) && (addr % 2 != 0)) return 1'b1;
    if ((op == 4 || op == 7) && (addr % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ext(input int v, input int bits, input bit sgn);
    int r;
    r = v;
    if (sgn && r >= (1 << (bits - 1))) r = r - (1 << bits);
    return 32'(r);
  endfunction

  // Both the DUT-side memory and the reference are updated; call with the DUT idle or in DONE.
  task automatic poke(input logic [31:0] addr, input logic [31:0] w);
    int a;
    a = int'({addr[9:2], 2'b00});
    for (int k = 0; k < 4; k++) ref_mem[a+k] = w[8*k +: 8];
    poke_en   = 1'b1;
    poke_idx  = addr[9:2];
    poke_data = w;
    @(posedge clock);
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge where the response is visible.
  task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input int op,
                       input logic [31:0] wd);
    bit          flt;
    bit          done;
    int          a, exp_lat, exp_stb, lat, nstb;
    logic [31:0] exp_rd, exp_ww, wa;
    a       = int'(addr[9:0]);
    wa      = {addr[31:2], 2'b00};
    flt     = ref_fault(op, addr);
    exp_rd  = 32'h0;
    exp_ww  = 32'h0;
    exp_lat = flt ? 1 : ((op == 5 || op == 6) ? 3 : 2);
    exp_stb = (!flt && op >= 5 && op <= 7) ? 1 : 0;
    if (!flt) begin
      case (op)
        0: exp_rd = ext(int'(ref_mem[a]), 8, 1'b1);
        1: exp_rd = ext(int'(ref_mem[a]), 8, 1'b0);
        2: exp_rd = ext(int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]), 16, 1'b1);
        3: exp_rd = ext(int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]), 16, 1'b0);
        4: exp_rd = ref_word(a);
        5: ref_mem[a] = wd[7:0];
        6: begin
          ref_mem[a]   = wd[7:0];
          ref_mem[a+1] = wd[15:8];
        end
        7: for (int k = 0; k < 4; k++) ref_mem[a+k] = wd[8*k +: 8];
        default: ;
      endcase
      exp_ww = ref_word(a);
    end

    req_valid = 1'b1;
    req_pc    = pc;
    req_addr  = addr;
    req_op    = 4'(op);
    req_wdata = wd;
    check_eq("req_ready_at_issue", 32'(req_ready), 32'h1);
    @(posedge clock);
    lat  = 0;
    nstb = 0;
    done = 1'b0;
    while (!done && lat < 8) begin
      @(negedge clock);
      lat++;
      if (mem_write_enabled) begin
        nstb++;
        check_eq("strobe_cycle", 32'(lat), 32'(exp_lat - 1));
        check_eq("strobe_addr", mem_address, wa);
        check_eq("strobe_data", mem_write_data, exp_ww);
        check_eq("strobe_pc", mem_pc, pc);
      end
      if (lat == 1) begin
        check_eq("access_addr", mem_address, flt ? 32'h0 : wa);
        check_eq("access_pc", mem_pc, flt ? 32'h0 : pc);
      end
      if (resp_valid) begin
        done = 1'b1;
      end else begin
        check_eq("req_ready_busy", 32'(req_ready), 32'h0);
        // Noise on the request bus while busy must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_op    = 4'($urandom);
        req_wdata = $urandom;
        req_pc    = $urandom;
      end
    end
    req_valid = 1'b0;
    if (!done) begin
      check_eq("resp_timeout", 32'(lat), 32'(exp_lat));
    end else begin
      check_eq("latency", 32'(lat), 32'(exp_lat));
      check_eq("resp_rdata", resp_rdata, exp_rd);
      check_eq("resp_fault", 32'(resp_fault), 32'(flt));
    end
    check_eq("strobe_count", 32'(nstb), 32'(exp_stb));
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_pc    = 32'h0;
    req_addr  = 32'h0;
    req_op    = 4'h0;
    req_wdata = 32'h0;
    poke_en   = 1'b0;
    poke_idx  = 8'h0;
    poke_data = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 256; i++) poke(32'(i * 4), $urandom);

    check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
    check_eq("rst_resp_rdata", resp_rdata, 32'h0);
    check_eq("rst_resp_fault", 32'(resp_fault), 32'h0);
    check_eq("rst_mem_we", 32'(mem_write_enabled), 32'h0);
    check_eq("rst_mem_addr", mem_address, 32'h0);
    check_eq("rst_mem_pc", mem_pc, 32'h0);
    check_eq("rst_mem_wdata", mem_write_data, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("ready_after_rst", 32'(req_ready), 32'h1);

    // Word store then load.
    issue(32'h100, 32'h10, 7, 32'hDEADBEEF);
    @(negedge clock);
    issue(32'h104, 32'h10, 4, 32'h0);
    check_eq("lw_dir", resp_rdata, 32'hDEADBEEF);
    @(negedge clock);

    // Sub-word loads.
    poke(32'h20, 32'h80FF7F01);
    issue(32'h108, 32'h23, 0, 32'h0);
    check_eq("lb_23", resp_rdata, 32'hFFFFFF80);
    issue(32'h10C, 32'h23, 1, 32'h0);
    check_eq("lbu_23", resp_rdata, 32'h00000080);
    issue(32'h110, 32'h21, 0, 32'h0);
    check_eq("lb_21", resp_rdata, 32'h0000007F);
    issue(32'h114, 32'h22, 2, 32'h0);
    check_eq("lh_22", resp_rdata, 32'hFFFF80FF);
    issue(32'h118, 32'h22, 3, 32'h0);
    check_eq("lhu_22", resp_rdata, 32'h000080FF);
    @(negedge clock);

    // Byte store read-modify-write.
    poke(32'h30, 32'h11223344);
    issue(32'h11C, 32'h31, 5, 32'hFFFFFFAB);
    issue(32'h120, 32'h30, 4, 32'h0);
    check_eq("sb_rmw_word", resp_rdata, 32'h1122AB44);

    // Faults.
    issue(32'h124, 32'h41, 4, 32'h0);
    issue(32'h128, 32'h43, 6, 32'h1234);
    issue(32'h12C, 32'h40, 9, 32'h0);
    @(negedge clock);

    // Back-to-back: second request accepted in the DONE cycle of the first.
    issue(32'h130, 32'h50, 7, 32'hCAFEF00D);
    issue(32'h134, 32'h50, 4, 32'h0);
    check_eq("b2b_lw", resp_rdata, 32'hCAFEF00D);
    @(negedge clock);

    // Reset during the WRITE cycle of an SH abandons it without a write.
    req_valid = 1'b1;
    req_pc    = 32'h138;
    req_addr  = 32'h62;
    req_op    = 4'd6;
    req_wdata = 32'h5555;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check_eq("sh_access_no_we", 32'(mem_write_enabled), 32'h0);
    @(negedge clock);
    check_eq("sh_write_we", 32'(mem_write_enabled), 32'h1);
    reset = 1'b1;
    #1;
    check_eq("rst_gates_we", 32'(mem_write_enabled), 32'h0);
    @(negedge clock);
    check_eq("rst_no_resp", 32'(resp_valid), 32'h0);
    reset = 1'b0;
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'h1);
    @(negedge clock);
    issue(32'h13C, 32'h60, 4, 32'h0);
    @(negedge clock);

    // Randomized traffic with random gaps (zero gap exercises DONE->ACCESS).
    for (int n = 0; n < 300; n++) begin
      issue($urandom, 32'($urandom_range(0, 1023)), $urandom_range(0, 9), $urandom);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator between the MEM pipeline stage and the word-only data memory.
- Accepts byte, halfword and word load/store requests through a valid/ready handshake.
- Sub-word loads are sign- or zero-extended. Sub-word stores become a read-modify-write of the enclosing word.
- Misaligned and illegal requests are flagged and never reach memory.

Parameters:
- ADDR_W, 32, byte address width of requests and of the memory port.
- DATA_W, 32, word width; fixed at 32, byte-lane logic assumes 4 lanes.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_pc  in  32  PC of the requesting instruction, forwarded to memory for trace.
- req_addr  in  32  byte address.
- req_op  in  4  operation code: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW; 8-15 illegal.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and faults.
- resp_fault  out  1  valid with resp_valid; misaligned or illegal op.
- mem_pc  out  32  PC of the access in flight.
- mem_address  out  32  word-aligned byte address {addr[31:2],2'b00}.
- mem_write_enabled  out  1  write strobe; the memory writes on the rising edge.
- mem_write_data  out  32  word to write.
- mem_read_data  in  32  combinational read of the word at mem_address.

Behaviour:
- States: IDLE, ACCESS, WRITE, DONE.
- Reset values: state IDLE; all outputs 0 except req_ready, which is 1 in the cycle after reset.
- Request latch: req_ready=1 in IDLE and DONE, 0 in ACCESS and WRITE. On req_valid&req_ready at edge E0, latch pc, addr, op and wdata.
- Fault check at E0: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, or op>=8 -> next state DONE with fault=1. Memory port stays idle.
- Otherwise -> ACCESS. mem_address = aligned latched addr and mem_pc = latched pc. mem_write_enabled=1 only for SW, with mem_write_data = wdata.
- Loads: at edge E1 (end of ACCESS) capture mem_read_data and extract the lane.
  - Byte lane k = addr[1:0] selects bits [8k+7:8k], little-endian.
  - Halfword uses addr[1]: 0 selects [15:0], 1 selects [31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through. Next state DONE.
- SW: the write happens at E1; next state DONE.
- SB/SH, cycle 1 (ACCESS): read only (mem_write_enabled=0). At E1 register the merged word: mem_read_data with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
- SB/SH, cycle 2 (WRITE): mem_address is held; mem_write_enabled=1 with the merged word. Next state DONE.
- DONE: resp_valid=1 for exactly one cycle with the registered rdata and fault.
  - Accepting a new request in DONE goes straight to ACCESS (or back to DONE on fault); otherwise return to IDLE.
- Latency, accept edge to resp_valid: 2 cycles for loads and SW, 3 for SB/SH, 1 for faults.
- When not in ACCESS/WRITE, mem_address, mem_pc and mem_write_data are 0 and mem_write_enabled is 0.
- Reset mid-operation: mem_write_enabled is gated by !reset, so no write occurs in a reset cycle. Any in-flight request is abandoned with no response; state returns to IDLE.
- req_* may change freely while req_ready=0; they are ignored.
- There is no response backpressure: the pipeline consumes resp_valid when it is asserted.

Decomposition:
- Shared package mem_pkg holds:
  - the op-code constants (OP_LB..OP_SW);
  - the state encoding;
  - a function for the lane-extract/extend of loads;
  - a function for the lane-merge of stores.
- One natural sub-module: mem_lane_align, combinational, covering extract-and-extend for loads and merge for stores. It is instantiated once; the FSM stays in the top module.

Test Plan:
- Word store/load: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> one write strobe, mem_address 0x10; LW returns 0xDEADBEEF, 2 cycles after accept, fault 0.
- Byte loads: memory word at 0x20 = 0x80FF7F01. LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LB 0x21 -> 0x0000007F; LH 0x22 -> 0xFFFF80FF; LHU 0x22 -> 0x000080FF.
- Byte store RMW: word at 0x30 = 0x11223344, SB 0x31 data 0xAB -> ACCESS read with no strobe, then WRITE strobe with 0x1122AB44. resp_valid 3 cycles after accept; a following LW returns 0x1122AB44.
- Faults: LW 0x41, SH 0x43 and op 9 -> resp_valid 1 cycle after accept, fault 1, rdata 0, and mem_write_enabled never asserted.
- Back-to-back: hold req_valid with SW 0x50, then LW 0x50 -> second request accepted in the DONE cycle of the first; LW result correct with no idle cycle in between.
- Reset during WRITE of an SH -> no write strobe in the reset cycle, no resp_valid, and req_ready=1 on the next cycle.
